// File: rtl/fdp_pkg.sv
// Shared constants and helpers for the FIFO drain packer.
package fdp_pkg;

  localparam int FDP_DEF_WIDTH = 8;  // bits per FIFO entry (one lane)
  localparam int FDP_DEF_PACK  = 4;  // lanes per output word
  localparam int FDP_MAX_PACK  = 8;  // largest supported lane count

  // Keep mask with the n lowest lanes set: (1 << n) - 1.
  function automatic logic [FDP_MAX_PACK-1:0] KEEP_MASK(input int n);
    logic [FDP_MAX_PACK:0] one;
    one = (FDP_MAX_PACK+1)'(1);
    return FDP_MAX_PACK'((one << n) - one);
  endfunction

endpackage

// File: rtl/fdp_out_stage.sv
// Output holding register of the FIFO drain packer: keeps a word stable
// until the consumer takes it, and can reload in the acceptance cycle.
module fdp_out_stage
  import fdp_pkg::*;
#(
  parameter int WIDTH = FDP_DEF_WIDTH,
  parameter int PACK  = FDP_DEF_PACK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [WIDTH*PACK-1:0]  i_data,
  input  logic [PACK-1:0]        i_keep,
  input  logic                   i_last,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [WIDTH*PACK-1:0]  o_data,
  output logic [PACK-1:0]        o_keep,
  output logic                   o_last,
  output logic                   o_can_load
);

  logic                  r_valid;
  logic [WIDTH*PACK-1:0] r_data;
  logic [PACK-1:0]       r_keep;
  logic                  r_last;

  // A new word may enter when the register is empty or being drained now.
  assign o_can_load = !r_valid || i_ready;

  // Load a word, or drop valid once the held word has been accepted.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

endmodule

// File: rtl/fifo_drain_packer.sv
// Drains a registered-flag FIFO and packs PACK entries per output word.
// Lane 0 (LSBs) holds the earliest entry; flush closes a partial word.
// Optional: define FDP_WORD_COUNT_EN to build the accepted-word counter;
// without it word_count is tied to zero.
module fifo_drain_packer
  import fdp_pkg::*;
#(
  parameter int WIDTH = FDP_DEF_WIDTH,
  parameter int PACK  = FDP_DEF_PACK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_dequeue,
  input  logic [WIDTH-1:0]       fifo_rdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*PACK-1:0]  out_data,
  output logic [PACK-1:0]        out_keep,
  output logic                   out_last,
  output logic [31:0]            word_count
);

  localparam int CNT_W  = $clog2(PACK+1);
  localparam int WORD_W = WIDTH*PACK;

  logic [CNT_W-1:0]  r_cnt;         // lanes already captured
  logic              r_inflight;    // read data arrives this cycle
  logic              r_flush_pend;  // flush waiting for in-flight data
  logic [WORD_W-1:0] r_asm;         // word under assembly

  logic              w_can_load;
  logic              w_last_lane;
  logic              w_load_full;
  logic              w_load_part;
  logic              w_load;
  logic              w_flush_pend_nxt;
  logic [WORD_W-1:0] w_word;
  logic [PACK-1:0]   w_keep;

  // The final lane may close the word in the same cycle it arrives, which
  // is what gives PACK entries per PACK+1 cycles.
  assign w_last_lane = r_inflight && (r_cnt == CNT_W'(PACK-1));
  assign w_load_full = ((r_cnt == CNT_W'(PACK)) || w_last_lane) && w_can_load;
  assign w_load_part = r_flush_pend && !r_inflight && (r_cnt != '0)
                       && (r_cnt != CNT_W'(PACK)) && w_can_load;
  assign w_load      = w_load_full || w_load_part;

  // Never request while empty, pending a flush, or with no free lane.
  assign fifo_dequeue = !rst && !fifo_empty && !r_flush_pend
                        && ((int'(r_cnt) + int'(r_inflight)) < PACK);

  // Assembly word with the arriving entry merged into lane r_cnt.
  // NOTE: default assignment first so no path leaves w_word unassigned (no latch).
  always_comb begin
    w_word = r_asm;
    for (int i = 0; i < PACK; i++) begin
      if (r_inflight && (r_cnt == CNT_W'(i))) begin
        w_word[i*WIDTH +: WIDTH] = fifo_rdata;
      end
    end
  end

  assign w_keep = w_load_full ? '1 : PACK'(KEEP_MASK(int'(r_cnt)));

  // Flush bookkeeping: absorbed while pending, no-op when nothing is held.
  always_comb begin
    w_flush_pend_nxt = r_flush_pend;
    if (r_flush_pend) begin
      if (w_load_part || (!r_inflight && (r_cnt == '0))) begin
        w_flush_pend_nxt = 1'b0;
      end
    end else if (flush && (r_inflight || (r_cnt != '0))) begin
      w_flush_pend_nxt = 1'b1;
    end
  end

  // Lane capture, word hand-off and flush state.
  // NOTE: r_asm is reset and cleared on every hand-off so the unused lanes
  // of a partial word are always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_asm        <= '0;
    end else begin
      r_inflight   <= fifo_dequeue;
      r_flush_pend <= w_flush_pend_nxt;
      if (w_load) begin
        r_cnt <= '0;
        r_asm <= '0;
      end else if (r_inflight) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_asm <= w_word;
      end
    end
  end

  fdp_out_stage #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_word),
    .i_keep     (w_keep),
    .i_last     (w_load_part),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_keep     (out_keep),
    .o_last     (out_last),
    .o_can_load (w_can_load)
  );

`ifdef FDP_WORD_COUNT_EN
  logic [31:0] r_word_count;

  // Count words taken by the consumer; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (out_valid && out_ready) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a registered-flag FIFO model.
module tb_fifo_drain_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_dequeue;
  logic [7:0]  fifo_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic [31:0] word_count;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    int          t;
  } word_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          pops     = 0;
  int          deq_empty_viol = 0;
  int          underflow      = 0;
  int          stab_viol      = 0;
  logic        gate_en = 1'b0;
  logic        gate    = 1'b0;
  logic        deq_now;
  logic        hold = 1'b0;
  logic [36:0] saved;
  logic [7:0]  fifo_q[$];
  word_t       rx_q[$];
  int          exp_wc;

  fifo_drain_packer #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_dequeue (fifo_dequeue),
    .fifo_rdata   (fifo_rdata),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_word(input int idx, input string tag,
                            input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w = rx_q[idx];
    check({tag, "_data"}, w.data, d);
    check({tag, "_keep"}, w.keep, k);
    check({tag, "_last"}, w.last, l);
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rx_q.size() < n) check("timeout_words", rx_q.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
  endtask

  // FIFO model, output monitor and protocol watchers, all on the clock edge.
  initial begin
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      deq_now = fifo_dequeue;
      if (fifo_dequeue && fifo_empty) deq_empty_viol++;
      if (!rst && out_valid && out_ready) rx_q.push_back('{out_data, out_keep, out_last, cyc});
      if (hold && out_valid && ({out_data, out_keep, out_last} !== saved)) stab_viol++;
      hold  = out_valid && !out_ready;
      saved = {out_data, out_keep, out_last};
      #1;
      if (deq_now) begin
        if (fifo_q.size() > 0) begin
          fifo_rdata = fifo_q.pop_front();
          pops++;
        end else begin
          underflow++;
        end
      end
      gate       = gate_en ? !gate : 1'b0;
      fifo_empty = (fifo_q.size() == 0) || gate;
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state, with entries already waiting in the FIFO.
    push_seq(8'h11, 8);
    idle(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_keep", out_keep, 4'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_deq", fifo_dequeue, 1'b0);
    check("rst_wc", word_count, 32'h0);

    // Two full words at full rate.
    rst = 1'b0;
    wait_words(2, 60);
    check_word(0, "full0", 32'h14131211, 4'hF, 1'b0);
    check_word(1, "full1", 32'h18171615, 4'hF, 1'b0);
    check("tput", rx_q[1].t - rx_q[0].t, 5);

    // Three entries closed by flush; no dequeue while the flush is pending.
    idle(5);
    rx_q.delete();
    push_seq(8'hA1, 3);
    idle(12);
    check("noflush_words", rx_q.size(), 0);
    flush = 1'b1;
    fifo_q.push_back(8'hB1);
    @(negedge clk);
    flush = 1'b0;
    check("pend_empty", fifo_empty, 1'b0);
    check("pend_deq", fifo_dequeue, 1'b0);
    @(negedge clk);
    check("resume_deq", fifo_dequeue, 1'b1);
    @(negedge clk);
    flush = 1'b1;   // cnt = 0 with one entry in flight
    @(negedge clk);
    flush = 1'b0;
    wait_words(2, 40);
    check_word(0, "part3", 32'h00A3A2A1, 4'h7, 1'b1);
    check_word(1, "part1", 32'h000000B1, 4'h1, 1'b1);

    // Flush with nothing held, then a double flush on a two-lane word.
    idle(6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(8);
    check("noop_words", rx_q.size(), 2);
    check("noop_valid", out_valid, 1'b0);
    push_seq(8'hC1, 2);
    idle(8);
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    idle(10);
    check("dbl_words", rx_q.size(), 3);
    check_word(2, "part2", 32'h0000C2C1, 4'h3, 1'b1);

    // Back-pressure: only two words' worth is pulled in.
    rx_q.delete();
    out_ready = 1'b0;
    pops = 0;
    push_seq(8'h21, 12);
    idle(30);
    check("bp_pops", pops, 8);
    check("bp_valid", out_valid, 1'b1);
    check("bp_data", out_data, 32'h24232221);
    out_ready = 1'b1;
    wait_words(3, 60);
    check_word(0, "bp0", 32'h24232221, 4'hF, 1'b0);
    check_word(1, "bp1", 32'h28272625, 4'hF, 1'b0);
    check_word(2, "bp2", 32'h2C2B2A29, 4'hF, 1'b0);

    // Empty flag toggling every cycle.
    idle(4);
    rx_q.delete();
    gate_en = 1'b1;
    push_seq(8'h31, 8);
    wait_words(2, 100);
    gate_en = 1'b0;
    check_word(0, "tog0", 32'h34333231, 4'hF, 1'b0);
    check_word(1, "tog1", 32'h38373635, 4'hF, 1'b0);

    // Reset mid-word with a word held at the output.
    idle(4);
    rx_q.delete();
    out_ready = 1'b0;
    pops = 0;
    push_seq(8'h41, 6);
    idle(20);
    check("mid_pops", pops, 6);
    check("mid_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_keep", out_keep, 4'h0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_deq", fifo_dequeue, 1'b0);
    fifo_q.delete();
    push_seq(8'h51, 4);
    idle(3);
    check("mid_rst_deq_held", fifo_dequeue, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_words(1, 40);
    check_word(0, "post_rst", 32'h54535251, 4'hF, 1'b0);

    // Five words after a clean reset for the word counter.
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    rx_q.delete();
    push_seq(8'h60, 20);
    wait_words(5, 120);
    idle(3);
    check_word(4, "wc_word4", 32'h73727170, 4'hF, 1'b0);
`ifdef FDP_WORD_COUNT_EN
    exp_wc = 5;
`else
    exp_wc = 0;
`endif
    check("word_count", word_count, exp_wc);

    // Protocol watchers over the whole run.
    check("deq_while_empty", deq_empty_viol, 0);
    check("fifo_underflow", underflow, 0);
    check("out_stability", stab_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
